// File: rtl/mem_port_arbiter.sv
// Two-client arbiter for one in-order memory port; an ID FIFO routes responses back to their requester.
// Define MEM_PORT_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise client 1 has fixed priority.
module mem_port_arbiter #(
  parameter int p_max_in_flight = 16,
  parameter int p_opaque_bits   = 8
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       c0_req_val,
  output logic                       c0_req_rdy,
  input  logic [68+p_opaque_bits:0]  c0_req_msg,
  output logic                       c0_resp_val,
  input  logic                       c0_resp_rdy,
  output logic [68+p_opaque_bits:0]  c0_resp_msg,

  input  logic                       c1_req_val,
  output logic                       c1_req_rdy,
  input  logic [68+p_opaque_bits:0]  c1_req_msg,
  output logic                       c1_resp_val,
  input  logic                       c1_resp_rdy,
  output logic [68+p_opaque_bits:0]  c1_resp_msg,

  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic [68+p_opaque_bits:0]  mem_req_msg,
  input  logic                       mem_resp_val,
  output logic                       mem_resp_rdy,
  input  logic [68+p_opaque_bits:0]  mem_resp_msg
);

  localparam int c_ptr_bits = $clog2(p_max_in_flight);
  localparam int c_cnt_bits = c_ptr_bits + 1;

  logic [c_cnt_bits-1:0] count;
  logic [c_ptr_bits-1:0] head;
  logic [c_ptr_bits-1:0] tail;
  logic                  id_fifo [p_max_in_flight];

  logic full;
  logic empty;
  logic can_issue;
  logic grant;
  logic head_id;
  logic req_xfer;
  logic resp_xfer;

  // Holding reset low forces full and empty so every handshake output drops immediately.
  assign full  = ~rst | (count == c_cnt_bits'(p_max_in_flight));
  assign empty = ~rst | (count == '0);

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  logic prio;

  always_comb begin
    grant = c1_req_val;
    if (c0_req_val && c1_req_val) grant = prio;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          prio <= 1'b0;
    else if (req_xfer) prio <= ~grant;
  end
`else
  assign grant = c1_req_val;
`endif

  // Fullness looks only at count, never at this cycle's pop, so there is no resp-to-req path.
  assign can_issue   = mem_req_rdy & ~full;
  assign mem_req_val = (c0_req_val | c1_req_val) & ~full;
  assign mem_req_msg = grant ? c1_req_msg : c0_req_msg;
  assign c0_req_rdy  = can_issue & ~grant;
  assign c1_req_rdy  = can_issue &  grant;
  assign req_xfer    = mem_req_val & mem_req_rdy;

  assign head_id      = id_fifo[head];
  assign mem_resp_rdy = ~empty & (head_id ? c1_resp_rdy : c0_resp_rdy);
  assign c0_resp_val  = ~empty & mem_resp_val & ~head_id;
  assign c1_resp_val  = ~empty & mem_resp_val &  head_id;
  assign c0_resp_msg  = mem_resp_msg;
  assign c1_resp_msg  = mem_resp_msg;
  assign resp_xfer    = mem_resp_val & mem_resp_rdy;

  // NOTE: the ID storage has no reset; entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (req_xfer) id_fifo[tail] <= grant;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (req_xfer)  tail <= tail + c_ptr_bits'(1);
      if (resp_xfer) head <= head + c_ptr_bits'(1);
      case ({req_xfer, resp_xfer})
        2'b10:   count <= count + c_cnt_bits'(1);
        2'b01:   count <= count - c_cnt_bits'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a queue-based in-order memory model and a response log.
module tb_mem_port_arbiter;

  localparam int c_opq = 8;
  localparam int c_w   = 69 + c_opq;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  localparam bit c_rr = 1'b1;
`else
  localparam bit c_rr = 1'b0;
`endif

  typedef struct {
    int          client;
    logic [31:0] addr;
  } resp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           c0_req_val, c0_req_rdy, c0_resp_val, c0_resp_rdy;
  logic           c1_req_val, c1_req_rdy, c1_resp_val, c1_resp_rdy;
  logic [c_w-1:0] c0_req_msg, c0_resp_msg, c1_req_msg, c1_resp_msg;
  logic           mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  logic [c_w-1:0] mem_req_msg, mem_resp_msg;

  logic [c_w-1:0] mem_q [$];
  resp_t          resp_log [$];
  resp_t          exp_q [$];
  int             mem_credit;
  int             c1_val_seen;
  int             vectors;
  int             miscompares;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .c0_req_val   (c0_req_val),
    .c0_req_rdy   (c0_req_rdy),
    .c0_req_msg   (c0_req_msg),
    .c0_resp_val  (c0_resp_val),
    .c0_resp_rdy  (c0_resp_rdy),
    .c0_resp_msg  (c0_resp_msg),
    .c1_req_val   (c1_req_val),
    .c1_req_rdy   (c1_req_rdy),
    .c1_req_msg   (c1_req_msg),
    .c1_resp_val  (c1_resp_val),
    .c1_resp_rdy  (c1_resp_rdy),
    .c1_resp_msg  (c1_resp_msg),
    .mem_req_val  (mem_req_val),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_msg  (mem_req_msg),
    .mem_resp_val (mem_resp_val),
    .mem_resp_rdy (mem_resp_rdy),
    .mem_resp_msg (mem_resp_msg)
  );

  function automatic logic [c_w-1:0] mk_msg(input logic [31:0] addr);
    return {1'b0, c_opq'(8'hA5), addr, 4'hF, ~addr};
  endfunction

  function automatic logic [31:0] addr_of(input logic [c_w-1:0] msg);
    return msg[67:36];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_resp(input string tag, input int idx, input int client, input logic [31:0] addr);
    if (idx < resp_log.size()) begin
      check({tag, "_client"}, resp_log[idx].client, client);
      check({tag, "_addr"}, resp_log[idx].addr, addr);
    end else begin
      check({tag, "_missing"}, resp_log.size(), idx + 1);
    end
  endtask

  task automatic wait_resp(input string tag, input int n);
    for (int k = 0; k < 300 && resp_log.size() < n; k++) @(negedge clk);
    check(tag, resp_log.size(), n);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    c0_req_val = 1'b0;  c1_req_val = 1'b0;
    c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    mem_req_rdy = 1'b1; mem_credit = 0;
    mem_q.delete(); resp_log.delete(); exp_q.delete();
    c1_val_seen = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Observer: records accepted requests and delivered responses on each active edge.
  always @(posedge clk) begin
    if (rst) begin
      if (mem_req_val && mem_req_rdy) mem_q.push_back(mem_req_msg);
      if (mem_resp_val && mem_resp_rdy) begin
        if (mem_q.size() > 0) void'(mem_q.pop_front());
        if (mem_credit > 0) mem_credit--;
      end
      if (c0_resp_val && c0_resp_rdy) resp_log.push_back('{0, addr_of(c0_resp_msg)});
      if (c1_resp_val && c1_resp_rdy) resp_log.push_back('{1, addr_of(c1_resp_msg)});
      if (c1_resp_val) c1_val_seen++;
    end
  end

  // Memory model: echoes each request back as its response, one per credit.
  always @(negedge clk) begin
    mem_resp_val = (mem_credit > 0) && (mem_q.size() > 0);
    mem_resp_msg = (mem_q.size() > 0) ? mem_q[0] : '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, n1, g, accepted;
    vectors = 0; miscompares = 0;
    rst = 1'b0; mem_credit = 0; c1_val_seen = 0;
    c0_req_msg = '0; c1_req_msg = '0;
    c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1; mem_req_rdy = 1'b1;
    c0_req_val = 1'b1; c1_req_val = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req_val", mem_req_val, 0);
    check("rst_c0_req_rdy", c0_req_rdy, 0);
    check("rst_c1_req_rdy", c1_req_rdy, 0);
    check("rst_mem_resp_rdy", mem_resp_rdy, 0);
    check("rst_c0_resp_val", c0_resp_val, 0);

    // Single client: three back-to-back c0 requests.
    reset_dut();
    mem_credit = 1000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c0_req_val = 1'b1; c0_req_msg = mk_msg(32'h200 + 4 * i);
      #1 check("t1_c0_req_rdy", c0_req_rdy, 1);
    end
    @(negedge clk);
    c0_req_val = 1'b0;
    wait_resp("t1_resp_count", 3);
    for (int i = 0; i < 3; i++) check_resp("t1_resp", i, 0, 32'h200 + 4 * i);
    check("t1_c1_resp_val_seen", c1_val_seen, 0);
    #1 check("t1_empty_mem_resp_rdy", mem_resp_rdy, 0);

    // Valid must not wait on memory ready.
    @(negedge clk);
    mem_req_rdy = 1'b0; c0_req_val = 1'b1; c0_req_msg = mk_msg(32'h300);
    #1;
    check("t1b_mem_req_val", mem_req_val, 1);
    check("t1b_c0_req_rdy", c0_req_rdy, 0);
    @(negedge clk);
    c0_req_val = 1'b0; mem_req_rdy = 1'b1;

    // Interleave: both clients valid for four cycles.
    reset_dut();
    mem_credit = 1000000;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c0_req_val = 1'b1; c0_req_msg = mk_msg(32'h200 + 4 * n0);
      c1_req_val = 1'b1; c1_req_msg = mk_msg(32'h1000 + 4 * n1);
      g = c_rr ? (i % 2) : 1;
      #1;
      check("t2_c0_req_rdy", c0_req_rdy, g == 0);
      check("t2_c1_req_rdy", c1_req_rdy, g == 1);
      check("t2_mem_req_addr", addr_of(mem_req_msg), (g == 1) ? 32'h1000 + 4 * n1 : 32'h200 + 4 * n0);
      if (g == 1) begin
        exp_q.push_back('{1, 32'h1000 + 4 * n1}); n1++;
      end else begin
        exp_q.push_back('{0, 32'h200 + 4 * n0}); n0++;
      end
    end
    @(negedge clk);
    c0_req_val = 1'b0; c1_req_val = 1'b0;
    wait_resp("t2_resp_count", 4);
    for (int i = 0; i < 4; i++) check_resp("t2_resp", i, exp_q[i].client, exp_q[i].addr);

    // Full: memory silent, sixteen requests fill the FIFO.
    reset_dut();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      c0_req_val = 1'b1; c0_req_msg = mk_msg(32'h200 + 4 * (k - 1));
      #1 check($sformatf("t3_c0_req_rdy_%0d", k), c0_req_rdy, k <= 16);
    end
    check("t3_full_mem_req_val", mem_req_val, 0);
    mem_credit = 1;
    @(negedge clk);
    #1;
    check("t3_pop_cycle_c0_req_rdy", c0_req_rdy, 0);
    check("t3_pop_cycle_mem_resp_rdy", mem_resp_rdy, 1);
    @(negedge clk);
    #1;
    check("t3_after_pop_c0_req_rdy", c0_req_rdy, 1);
    check("t3_after_pop_mem_req_val", mem_req_val, 1);
    @(negedge clk);
    c0_req_val = 1'b0;

    // Head-of-line blocking: c1 response at head, c1 not ready.
    reset_dut();
    @(negedge clk);
    c1_req_val = 1'b1; c1_req_msg = mk_msg(32'h1000);
    @(negedge clk);
    c1_req_val = 1'b0; c0_req_val = 1'b1; c0_req_msg = mk_msg(32'h200);
    @(negedge clk);
    c0_req_val = 1'b0; c1_resp_rdy = 1'b0;
    #1 mem_credit = 1000000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("t4_mem_resp_rdy", mem_resp_rdy, 0);
      check("t4_c1_resp_val", c1_resp_val, 1);
      check("t4_c0_resp_val", c0_resp_val, 0);
    end
    check("t4_no_pop", resp_log.size(), 0);
    c1_resp_rdy = 1'b1;
    wait_resp("t4_resp_count", 2);
    check_resp("t4_resp0", 0, 1, 32'h1000);
    check_resp("t4_resp1", 1, 0, 32'h200);

    // Simultaneous push and pop at count 5, then fill to prove count stayed 5.
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      c0_req_val = 1'b1; c0_req_msg = mk_msg(32'h200 + 4 * k);
    end
    #1 mem_credit = 1;
    @(negedge clk);
    c0_req_msg = mk_msg(32'h214);
    #1;
    check("t5_push_rdy", c0_req_rdy, 1);
    check("t5_pop_rdy", mem_resp_rdy, 1);
    accepted = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      c0_req_msg = mk_msg(32'h218 + 4 * accepted);
      #1 if (c0_req_rdy) accepted++;
    end
    check("t5_fill_accepted", accepted, 11);
    c0_req_val = 1'b0;
    mem_credit = 1000000;
    wait_resp("t5_resp_count", 17);
    for (int i = 0; i < 17; i++) check_resp("t5_resp", i, 0, 32'h200 + 4 * i);

    // Wrap: 40 alternating requests cycle head and tail through the FIFO.
    reset_dut();
    mem_credit = 1000000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      c0_req_val = (i % 2 == 0); c0_req_msg = mk_msg(32'h200 + 4 * i);
      c1_req_val = (i % 2 == 1); c1_req_msg = mk_msg(32'h1000 + 4 * i);
    end
    @(negedge clk);
    c0_req_val = 1'b0; c1_req_val = 1'b0;
    wait_resp("t6_resp_count", 40);
    for (int i = 0; i < 40; i++)
      check_resp("t6_resp", i, i % 2, (i % 2 == 1) ? 32'h1000 + 4 * i : 32'h200 + 4 * i);

    // Asynchronous reset with seven requests outstanding.
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      c0_req_val = 1'b1; c0_req_msg = mk_msg(32'h300 + 4 * k);
    end
    @(negedge clk);
    c0_req_msg = mk_msg(32'h400); c1_req_val = 1'b1;
    #3 rst = 1'b0;
    #1;
    check("t7_mem_req_val", mem_req_val, 0);
    check("t7_c0_req_rdy", c0_req_rdy, 0);
    check("t7_c1_req_rdy", c1_req_rdy, 0);
    check("t7_mem_resp_rdy", mem_resp_rdy, 0);
    check("t7_c0_resp_val", c0_resp_val, 0);
    check("t7_c1_resp_val", c1_resp_val, 0);
    mem_credit = 1000000;
    @(negedge clk);
    #1;
    check("t7_held_mem_resp_rdy", mem_resp_rdy, 0);
    check("t7_held_c0_resp_val", c0_resp_val, 0);
    c0_req_val = 1'b0; c1_req_val = 1'b0;
    mem_q.delete(); resp_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("t7_post_rst_mem_resp_rdy", mem_resp_rdy, 0);
    @(negedge clk);
    c0_req_val = 1'b1; c0_req_msg = mk_msg(32'h200);
    #1;
    check("t7_fresh_mem_req_val", mem_req_val, 1);
    check("t7_fresh_c0_req_rdy", c0_req_rdy, 1);
    check("t7_fresh_mem_req_addr", addr_of(mem_req_msg), 32'h200);
    @(negedge clk);
    c0_req_val = 1'b0;
    wait_resp("t7_resp_count", 1);
    check_resp("t7_resp", 0, 0, 32'h200);
    repeat (3) @(negedge clk);
    check("t7_resp_only_one", resp_log.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
